qsys_key_pio_in: RTL and testbench

Avalon-MM slave input PIO, the read-side counterpart of the team's LED output PIO. It samples WIDTH asynchronous board inputs (KEY/SW), synchronises and debounces each bit, and captures edges per bit into a sticky register. It raises a level interrupt for the Nios II through a per-bit mask. It sits in the Qsys system beside the LED PIO on the same 50 MHz clk domain.

---
 rtl/qsys_key_pio_in.sv | 180 ++++++++++++++++++
 tb/tb_qsys_key_pio_in.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/qsys_key_pio_in.sv
// -----------------------------------------------------------------------------
// qsys_key_pio_in
//   Avalon-MM slave input PIO for board keys/switches. Each of the WIDTH raw
//   asynchronous inputs is synchronised (two flops), debounced (a level must
//   persist DEBOUNCE_CYCLES synchronised clocks) and its accepted transitions
//   are latched into a sticky write-1-to-clear edge_capture register. A level
//   interrupt is raised when any captured edge is enabled in irq_mask.
//
// Parameters
//   WIDTH            number of input bits (1..32)
//   DEBOUNCE_CYCLES  consecutive stable clocks to accept a new level (>=1)
//   EDGE_TYPE        captured edges: 0 rising, 1 falling, 2 any
//   INIT_VALUE       reset value of synchroniser and debounced registers
//
// Ports
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   address     Avalon word address (0 data, 1 reserved, 2 irq_mask,
//               3 edge_capture)
//   chipselect  Avalon slave select
//   write_n     active-low write strobe
//   writedata   write data
//   read_n      active-low read strobe (reads have no side effects)
//   in_port     raw asynchronous board inputs
//   readdata    read data, combinational (read latency 0)
//   irq         level interrupt, active-high
// -----------------------------------------------------------------------------
module qsys_key_pio_in #(
   parameter int unsigned       WIDTH           = 4,
   parameter int unsigned       DEBOUNCE_CYCLES = 50000,
   parameter int unsigned       EDGE_TYPE       = 0,
   parameter logic [WIDTH-1:0]  INIT_VALUE      = '0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [1:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   input  logic              read_n,
   input  logic [WIDTH-1:0]  in_port,
   output logic [31:0]       readdata,
   output logic              irq
);

   localparam int unsigned        CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   localparam logic [1:0] ADDR_DATA  = 2'd0;
   localparam logic [1:0] ADDR_MASK  = 2'd2;
   localparam logic [1:0] ADDR_EDGE  = 2'd3;

   // Synchroniser, debounced level and per-bit stability counters
   logic [WIDTH-1:0]  r_sync1;
   logic [WIDTH-1:0]  r_sync2;
   logic [WIDTH-1:0]  r_data;
   logic [CNT_W-1:0]  r_cnt [WIDTH];

   // Software-visible registers
   logic [WIDTH-1:0]  r_irq_mask;
   logic [WIDTH-1:0]  r_edge;

   logic [WIDTH-1:0]  w_mismatch;
   logic [WIDTH-1:0]  w_accept;
   logic [WIDTH-1:0]  w_rise;
   logic [WIDTH-1:0]  w_fall;
   logic [WIDTH-1:0]  w_set;
   logic [WIDTH-1:0]  w_clr;
   logic              w_wr;
   logic              w_wr_mask;
   logic              w_wr_edge;

   // read_n and the upper writedata bits do not influence any state
   logic              w_unused_inputs;
   assign w_unused_inputs = &{1'b0, read_n, writedata};

   // --------------------------------------------------------------------------
   // Two-flop synchroniser
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= INIT_VALUE;
         r_sync2 <= INIT_VALUE;
      end else begin
         r_sync1 <= in_port;
         r_sync2 <= r_sync1;
      end
   end

   // --------------------------------------------------------------------------
   // Debounce: a bit is accepted on the edge where its counter has already
   // seen DEBOUNCE_CYCLES-1 mismatching cycles and the mismatch still holds.
   // --------------------------------------------------------------------------
   assign w_mismatch = r_sync2 ^ r_data;

   always_comb begin
      w_accept = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         w_accept[i] = w_mismatch[i] && (r_cnt[i] == CNT_LAST);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_data <= INIT_VALUE;
         for (int unsigned i = 0; i < WIDTH; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < WIDTH; i++) begin
            if (w_accept[i]) begin
               r_data[i] <= r_sync2[i];
               r_cnt[i]  <= '0;
            end else if (w_mismatch[i]) begin
               r_cnt[i]  <= r_cnt[i] + 1'b1;
            end else begin
               r_cnt[i]  <= '0;
            end
         end
      end
   end

   // --------------------------------------------------------------------------
   // Edge detection on accepted transitions
   // --------------------------------------------------------------------------
   assign w_rise = w_accept &  r_sync2;
   assign w_fall = w_accept & ~r_sync2;

   always_comb begin
      w_set = '0;
      if (EDGE_TYPE == 0) begin
         w_set = w_rise;
      end else if (EDGE_TYPE == 1) begin
         w_set = w_fall;
      end else begin
         w_set = w_rise | w_fall;
      end
   end

   // --------------------------------------------------------------------------
   // Avalon write decode
   // --------------------------------------------------------------------------
   assign w_wr      = chipselect && !write_n;
   assign w_wr_mask = w_wr && (address == ADDR_MASK);
   assign w_wr_edge = w_wr && (address == ADDR_EDGE);
   assign w_clr     = w_wr_edge ? writedata[WIDTH-1:0] : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_irq_mask <= '0;
      end else if (w_wr_mask) begin
         r_irq_mask <= writedata[WIDTH-1:0];
      end
   end

   // Set is applied after clear so a capture coinciding with a clear survives
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_edge <= '0;
      end else begin
         r_edge <= (r_edge & ~w_clr) | w_set;
      end
   end

   // --------------------------------------------------------------------------
   // Read mux and interrupt
   // --------------------------------------------------------------------------
   always_comb begin
      readdata = '0;
      case (address)
         ADDR_DATA: readdata[WIDTH-1:0] = r_data;
         ADDR_MASK: readdata[WIDTH-1:0] = r_irq_mask;
         ADDR_EDGE: readdata[WIDTH-1:0] = r_edge;
         default:   readdata = '0;
      endcase
   end

   assign irq = |(r_edge & r_irq_mask);

endmodule

// File: tb/tb_qsys_key_pio_in.sv
// -----------------------------------------------------------------------------
// tb_qsys_key_pio_in
//   Two instances share all inputs: dut0 (rising edges, INIT 0x0) and
//   dut1 (any edge, INIT 0xF), both with DEBOUNCE_CYCLES=4. The reference
//   model keeps the raw input history since reset and accepts a new level
//   when the last DEBOUNCE_CYCLES synchronised samples all hold it and no
//   change occurred inside that window.
// -----------------------------------------------------------------------------
module tb_qsys_key_pio_in;

   localparam int unsigned W  = 4;
   localparam int unsigned DB = 4;

   logic          clk;
   logic          reset_n;
   logic [1:0]    address;
   logic          chipselect;
   logic          write_n;
   logic [31:0]   writedata;
   logic          read_n;
   logic [W-1:0]  in_port;
   logic [31:0]   rd0, rd1;
   logic          irq0, irq1;

   int checks   = 0;
   int failures = 0;

   qsys_key_pio_in #(
      .WIDTH(W), .DEBOUNCE_CYCLES(DB), .EDGE_TYPE(0), .INIT_VALUE(4'h0)
   ) dut0 (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .read_n(read_n),
      .in_port(in_port), .readdata(rd0), .irq(irq0)
   );

   qsys_key_pio_in #(
      .WIDTH(W), .DEBOUNCE_CYCLES(DB), .EDGE_TYPE(2), .INIT_VALUE(4'hF)
   ) dut1 (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .read_n(read_n),
      .in_port(in_port), .readdata(rd1), .irq(irq1)
   );

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   // ---------------------------------------------------------------- model
   int unsigned   m_et   [2] = '{0, 2};
   logic [W-1:0]  m_init [2] = '{4'h0, 4'hF};
   logic [W-1:0]  m_data [2];
   logic [W-1:0]  m_edge [2];
   logic [W-1:0]  m_mask [2];
   int            m_since [2][W];
   logic [W-1:0]  xh[$];

   task automatic check_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Synchronised sample seen at clock edge idx (1-based since reset release)
   function automatic logic hist_bit(input int inst, input int idx, input int b);
      if (idx >= 1) return xh[idx-1][b];
      return m_init[inst][b];
   endfunction

   task automatic model_reset();
      for (int inst = 0; inst < 2; inst++) begin
         m_data[inst] = m_init[inst];
         m_edge[inst] = '0;
         m_mask[inst] = '0;
         for (int b = 0; b < W; b++) m_since[inst][b] = 0;
      end
      xh.delete();
   endtask

   task automatic model_step();
      int            k;
      logic          do_wr;
      logic [W-1:0]  set;
      logic [W-1:0]  nd;
      logic          v;
      logic          accept;
      k     = xh.size() + 1;
      do_wr = chipselect && !write_n;
      for (int inst = 0; inst < 2; inst++) begin
         set = '0;
         nd  = m_data[inst];
         for (int b = 0; b < W; b++) begin
            v      = hist_bit(inst, k - 2, b);
            accept = 1'b0;
            if (m_since[inst][b] >= int'(DB) - 1 && v != m_data[inst][b]) begin
               accept = 1'b1;
               for (int j = 1; j < int'(DB); j++)
                  if (hist_bit(inst, k - 2 - j, b) != v) accept = 1'b0;
            end
            if (accept) begin
               nd[b] = v;
               m_since[inst][b] = 0;
               if (m_et[inst] == 2 || (m_et[inst] == 0 && v) || (m_et[inst] == 1 && !v))
                  set[b] = 1'b1;
            end else begin
               m_since[inst][b]++;
            end
         end
         if (do_wr && address == 2'd2) m_mask[inst] = writedata[W-1:0];
         if (do_wr && address == 2'd3) m_edge[inst] = m_edge[inst] & ~writedata[W-1:0];
         m_edge[inst] = m_edge[inst] | set;
         m_data[inst] = nd;
      end
      xh.push_back(in_port);
   endtask

   function automatic logic [31:0] exp_rd(input int inst, input logic [1:0] a);
      case (a)
         2'd0:    return {28'b0, m_data[inst]};
         2'd2:    return {28'b0, m_mask[inst]};
         2'd3:    return {28'b0, m_edge[inst]};
         default: return 32'b0;
      endcase
   endfunction

   // ------------------------------------------------------------- stimulus
   task automatic tick();
      logic [1:0] keep;
      keep = address;
      @(posedge clk);
      if (reset_n) model_step();
      @(negedge clk);
      for (int a = 0; a < 4; a++) begin
         address = 2'(a);
         #1;
         check_eq($sformatf("rd0_a%0d", a), rd0, exp_rd(0, 2'(a)));
         check_eq($sformatf("rd1_a%0d", a), rd1, exp_rd(1, 2'(a)));
      end
      check_eq("irq0", {31'b0, irq0}, {31'b0, |(m_edge[0] & m_mask[0])});
      check_eq("irq1", {31'b0, irq1}, {31'b0, |(m_edge[1] & m_mask[1])});
      address = keep;
   endtask

   task automatic drive(input logic [W-1:0] in, input logic cs, input logic wn,
                        input logic [1:0] a, input logic [31:0] wd);
      in_port    = in;
      chipselect = cs;
      write_n    = wn;
      address    = a;
      writedata  = wd;
      read_n     = 1'b1;
   endtask

   task automatic idle(input logic [W-1:0] in, input int n);
      drive(in, 1'b0, 1'b1, 2'd0, 32'h0);
      repeat (n) tick();
   endtask

   task automatic do_reset(input int n);
      reset_n = 1'b0;
      model_reset();
      repeat (n) tick();
      reset_n = 1'b1;
   endtask

   initial begin
      int            lat;
      logic [W-1:0]  cur;
      int            hold [W];

      reset_n = 1'b0;
      drive(4'h0, 1'b0, 1'b1, 2'd0, 32'h0);
      do_reset(2);

      // Reset values and ignored write to the data register
      address = 2'd0; #1;
      check_eq("rst_data0", rd0, 32'h0);
      check_eq("rst_data1", rd1, 32'hF);
      drive(4'h0, 1'b1, 1'b0, 2'd0, 32'hF); tick();
      idle(4'h0, 2);

      // Step response latency: 2 sync + DB debounce clocks
      drive(4'h1, 1'b0, 1'b1, 2'd0, 32'h0);
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         #1;
         if (rd0[0] === 1'b1) begin
            lat = i;
            break;
         end
      end
      check_eq("step_latency", 32'(lat), 32'd6);
      idle(4'h1, 3);

      // Short glitch rejected, long pulse accepted both ways
      idle(4'h5, 3);
      idle(4'h1, 10);
      idle(4'h5, 6);
      idle(4'h1, 10);

      // Interrupt via mask, clear, clear of another bit keeps bit1
      drive(4'h1, 1'b1, 1'b0, 2'd2, 32'h2); tick();
      idle(4'h3, 10);
      drive(4'h3, 1'b1, 1'b0, 2'd3, 32'h2); tick();
      idle(4'h3, 2);
      idle(4'h1, 8);
      idle(4'h3, 8);
      drive(4'h3, 1'b1, 1'b0, 2'd3, 32'h1); tick();
      idle(4'h3, 2);

      // Clear coinciding with a new rising capture on bit0
      drive(4'h3, 1'b1, 1'b0, 2'd3, 32'hF); tick();
      idle(4'h2, 10);
      idle(4'h3, 5);
      drive(4'h3, 1'b1, 1'b0, 2'd3, 32'h1); tick();
      address = 2'd3; #1;
      check_eq("set_wins_bit0", rd0 & 32'h1, 32'h1);
      idle(4'h3, 2);

      // Falling/rising on bit3 for the any-edge instance, reset mid-debounce
      idle(4'hF, 10);
      drive(4'hF, 1'b1, 1'b0, 2'd3, 32'hF); tick();
      idle(4'h7, 8);
      idle(4'hF, 8);
      idle(4'h7, 4);
      do_reset(1);
      address = 2'd3; #1;
      check_eq("rst_mid_edge1", rd1, 32'h0);
      idle(4'h7, 10);

      // Randomised traffic
      cur = in_port;
      for (int b = 0; b < W; b++) hold[b] = int'($urandom_range(1, 9));
      for (int c = 0; c < 1500; c++) begin
         for (int b = 0; b < W; b++) begin
            hold[b]--;
            if (hold[b] <= 0) begin
               cur[b]  = ~cur[b];
               hold[b] = int'($urandom_range(1, 9));
            end
         end
         if ($urandom_range(0, 3) == 0)
            drive(cur, 1'b1, 1'b0, 2'($urandom_range(0, 3)), $urandom);
         else
            drive(cur, 1'($urandom_range(0, 1)), 1'b1, 2'($urandom_range(0, 3)), $urandom);
         read_n = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 299) == 0) do_reset(int'($urandom_range(1, 3)));
         else tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
